// File: rtl/pool_layer.sv
// pool_layer: 2x2 stride-2 max-pooling stage fed by conv_layer.
// Pixels arrive in raster order with all channels side by side. Each lane keeps
// a horizontal max register and a line buffer of half-row maxima. The odd-row /
// odd-column pixel closes a window, and the pooled pixel goes to the next layer.
// A one-deep pending register absorbs a single downstream stall. While a result
// is pending, o_ready drops so that no further window can complete.
module pool_layer #(
  parameter  int DATA_SIZE = 8,
  parameter  int IMG_DIM   = 26,
  parameter  int CHANNELS  = 4,
  parameter  int SIGNED    = 0,
  localparam int OUT_DIM   = IMG_DIM / 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CHANNELS-1:0]           i_we,
  input  logic [DATA_SIZE*CHANNELS-1:0] i_data,
  input  logic                          i_start,
  output logic                          o_ready,
  input  logic                          i_next_ready,
  output logic [DATA_SIZE*CHANNELS-1:0] o_next_data,
  output logic [CHANNELS-1:0]           o_next_we,
  output logic                          o_next_start
);

  localparam int CW  = (IMG_DIM > 2) ? $clog2(IMG_DIM) : 1;
  localparam int LBW = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam logic [CW-1:0] C_LAST  = CW'(IMG_DIM - 1);
  localparam logic          ODD_DIM = ((IMG_DIM % 2) != 0);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  // Larger of two elements. Signedness is fixed at elaboration. On a tie either
  // operand is returned, and both give the same value.
  function automatic logic [DATA_SIZE-1:0] f_max(input logic [DATA_SIZE-1:0] a,
                                                 input logic [DATA_SIZE-1:0] b);
    logic a_gt;
    if (SIGNED != 0) a_gt = ($signed(a) > $signed(b));
    else             a_gt = (a > b);
    return a_gt ? a : b;
  endfunction

  // i_start only marks pixel boundaries for conv-style consumers. Here the
  // write strobe alone carries that information, so i_start is not used.
  logic w_unused_start;
  assign w_unused_start = i_start;

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic [CW-1:0]                   r_row;
  logic [CW-1:0]                   r_col;
  logic                            r_ready;
  logic [CHANNELS-1:0]             r_next_we;
  logic                            r_next_start;
  logic [DATA_SIZE*CHANNELS-1:0]   r_next_data;
  logic [DATA_SIZE*CHANNELS-1:0]   r_pend_data;
  logic [DATA_SIZE-1:0]            r_h   [CHANNELS];
  logic [DATA_SIZE-1:0]            r_lb  [CHANNELS][OUT_DIM];

  logic                            w_accept;
  logic                            w_in_win;
  logic                            w_row_odd;
  logic                            w_col_odd;
  logic                            w_result_due;
  logic [LBW-1:0]                  w_lb_idx;
  logic [DATA_SIZE-1:0]            w_in      [CHANNELS];
  logic [DATA_SIZE-1:0]            w_max_hin [CHANNELS];
  logic [DATA_SIZE-1:0]            w_max_lbin[CHANNELS];
  logic [DATA_SIZE*CHANNELS-1:0]   w_result;
  logic                            w_emit_new;
  logic                            w_emit_pend;
  logic                            w_latch_pend;

  assign w_accept  = (|i_we) & r_ready;
  assign w_row_odd = r_row[0];
  assign w_col_odd = r_col[0];
  // With an odd map size, the last row and the last column are not part of any window.
  assign w_in_win  = !(ODD_DIM && ((r_row == C_LAST) || (r_col == C_LAST)));
  assign w_lb_idx  = LBW'(r_col >> 1);
  assign w_result_due = w_accept & w_in_win & w_row_odd & w_col_odd;

  // Per-lane comparators: new pixel against the horizontal register and against the line buffer.
  always_comb begin
    w_result = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_in[c]       = i_data[c*DATA_SIZE +: DATA_SIZE];
      w_max_hin[c]  = f_max(r_h[c], w_in[c]);
      w_max_lbin[c] = f_max(r_lb[c][w_lb_idx], w_in[c]);
      w_result[c*DATA_SIZE +: DATA_SIZE] = w_max_hin[c];
    end
  end

  // Raster position of the next pixel to be accepted. It wraps at the end of each row and frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_accept) begin
      if (r_col == C_LAST) begin
        r_col <= '0;
        if (r_row == C_LAST) r_row <= '0;
        else                 r_row <= r_row + CW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end else begin
      r_row <= r_row;
      r_col <= r_col;
    end
  end

  // Window accumulation storage. It does not need a reset, because every slot
  // is written before it is read within a frame.
  always_ff @(posedge clk) begin
    if (w_accept && w_in_win) begin
      for (int c = 0; c < CHANNELS; c++) begin
        case ({w_row_odd, w_col_odd})
          2'b00:   r_h[c] <= w_in[c];
          2'b01:   r_lb[c][w_lb_idx] <= w_max_hin[c];
          2'b10:   r_h[c] <= w_max_lbin[c];
          default: r_h[c] <= r_h[c];
        endcase
      end
    end
  end

  // Output-stage state register: running, or holding one undelivered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  // Next state: a stall begins when a result is due and downstream is busy.
  // The stall ends on the first cycle downstream is ready.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_result_due && !i_next_ready) w_state_nxt = ST_STALL;
        else                               w_state_nxt = ST_RUN;
      end
      ST_STALL: begin
        if (i_next_ready) w_state_nxt = ST_RUN;
        else              w_state_nxt = ST_STALL;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Output-stage controls: emit a fresh result, emit the pending one, or park a fresh result.
  always_comb begin
    w_emit_new   = 1'b0;
    w_emit_pend  = 1'b0;
    w_latch_pend = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_emit_new   = w_result_due & i_next_ready;
        w_latch_pend = w_result_due & ~i_next_ready;
      end
      ST_STALL: begin
        w_emit_pend  = i_next_ready;
      end
      default: begin
        w_emit_new   = 1'b0;
        w_emit_pend  = 1'b0;
        w_latch_pend = 1'b0;
      end
    endcase
  end

  // Registered handshake and data toward the next layer. o_next_start trails o_next_we by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready      <= 1'b1;
      r_next_we    <= '0;
      r_next_start <= 1'b0;
      r_next_data  <= '0;
      r_pend_data  <= '0;
    end else begin
      r_ready      <= (w_state_nxt == ST_RUN);
      r_next_we    <= (w_emit_new | w_emit_pend) ? {CHANNELS{1'b1}} : {CHANNELS{1'b0}};
      r_next_start <= |r_next_we;
      if (w_emit_new)       r_next_data <= w_result;
      else if (w_emit_pend) r_next_data <= r_pend_data;
      else                  r_next_data <= r_next_data;
      if (w_latch_pend)     r_pend_data <= w_result;
      else                  r_pend_data <= r_pend_data;
    end
  end

  assign o_ready      = r_ready;
  assign o_next_we    = r_next_we;
  assign o_next_start = r_next_start;
  assign o_next_data  = r_next_data;

endmodule

// File: tb/tb_pool_layer.sv
// tb_pool_layer: two pooling instances are driven from one clock.
// Instance A is 4x4 and unsigned. Instance B is 5x5 and signed.
// Both have 4 lanes of 8 bits.
module tb_pool_layer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, b_rst, a_start, b_start, a_nr, b_nr;
  logic [3:0]  a_we, b_we, a_nwe, b_nwe;
  logic [31:0] a_data, b_data, a_ndata, b_ndata;
  logic        a_ready, b_ready, a_nstart, b_nstart;

  pool_layer #(.DATA_SIZE(8), .IMG_DIM(4), .CHANNELS(4), .SIGNED(0)) u_a (
    .clk(clk), .rst(a_rst), .i_we(a_we), .i_data(a_data), .i_start(a_start),
    .o_ready(a_ready), .i_next_ready(a_nr), .o_next_data(a_ndata),
    .o_next_we(a_nwe), .o_next_start(a_nstart));

  pool_layer #(.DATA_SIZE(8), .IMG_DIM(5), .CHANNELS(4), .SIGNED(1)) u_b (
    .clk(clk), .rst(b_rst), .i_we(b_we), .i_data(b_data), .i_start(b_start),
    .o_ready(b_ready), .i_next_ready(b_nr), .o_next_data(b_ndata),
    .o_next_we(b_nwe), .o_next_start(b_nstart));

  int checks = 0;
  int failures = 0;
  logic [31:0] frame_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [3:0]  a_prev_we = 4'h0;
  logic [3:0]  b_prev_we = 4'h0;

  typedef struct {
    logic [31:0] w0, w1, w2, w3, exp;
  } vec_t;
  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Collect emitted pixels. Also check the all-lanes strobe and the start pulse that trails it.
  always @(negedge clk) begin
    if (a_nwe != 4'h0) begin
      qa.push_back(a_ndata);
      check("a_we_all", 32'(a_nwe), 32'hF);
    end
    if (a_prev_we != 4'h0 || a_nstart) check("a_start", 32'(a_nstart), 32'(a_prev_we != 4'h0));
    a_prev_we = a_rst ? 4'h0 : a_nwe;
    if (b_nwe != 4'h0) begin
      qb.push_back(b_ndata);
      check("b_we_all", 32'(b_nwe), 32'hF);
    end
    if (b_prev_we != 4'h0 || b_nstart) check("b_start", 32'(b_nstart), 32'(b_prev_we != 4'h0));
    b_prev_we = b_rst ? 4'h0 : b_nwe;
  end

  function automatic logic [7:0] mx(input logic [7:0] a, input logic [7:0] b, input bit sgn);
    if (sgn) return ($signed(a) > $signed(b)) ? a : b;
    return (a > b) ? a : b;
  endfunction

  // Reference model: each pooled pixel is the lane-wise maximum of its 2x2 block.
  task automatic model(input int dim, input bit sgn, input int base);
    int od;
    logic [31:0] p0, p1, p2, p3, v;
    od = dim / 2;
    for (int oy = 0; oy < od; oy++) begin
      for (int ox = 0; ox < od; ox++) begin
        p0 = frame_q[base + (2*oy)*dim + 2*ox];
        p1 = frame_q[base + (2*oy)*dim + 2*ox + 1];
        p2 = frame_q[base + (2*oy+1)*dim + 2*ox];
        p3 = frame_q[base + (2*oy+1)*dim + 2*ox + 1];
        for (int l = 0; l < 4; l++)
          v[l*8 +: 8] = mx(mx(p0[l*8 +: 8], p1[l*8 +: 8], sgn), mx(p2[l*8 +: 8], p3[l*8 +: 8], sgn), sgn);
        exp_q.push_back(v);
      end
    end
  endtask

  task automatic drv(input int sel, input logic [3:0] we, input logic [31:0] d);
    if (sel == 0) begin a_we = we; a_data = d; end
    else          begin b_we = we; b_data = d; end
  endtask

  task automatic set_nr(input int sel, input logic v);
    if (sel == 0) a_nr = v;
    else          b_nr = v;
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? a_ready : b_ready;
  endfunction

  function automatic logic [3:0] we_of(input int sel);
    return (sel == 0) ? a_nwe : b_nwe;
  endfunction

  // Send frame_q[from..to-1]. Each pixel waits (bounded) for o_ready.
  // In rnd mode, idle gaps and downstream stalls are inserted at random.
  // In lat mode, the output strobe is checked right after each accepting edge.
  task automatic send(input int sel, input int dim, input int from, input int to,
                      input bit rnd, input bit lat);
    int n, r, c;
    logic [3:0] ew;
    for (int i = from; i < to; i++) begin
      if (rnd && $urandom_range(0, 3) == 0) begin
        set_nr(sel, 1'($urandom_range(0, 1)));
        @(posedge clk); #1;
      end
      n = 0;
      while (rdy(sel) !== 1'b1 && n < 200) begin
        if (rnd) set_nr(sel, 1'($urandom_range(0, 1)));
        @(posedge clk); #1;
        n++;
      end
      if (n >= 200) begin
        check("ready_timeout", 32'(rdy(sel)), 32'h1);
        return;
      end
      if (rnd) set_nr(sel, 1'($urandom_range(0, 1)));
      drv(sel, 4'hF, frame_q[i]);
      @(posedge clk); #1;
      drv(sel, 4'h0, 32'h0);
      if (lat) begin
        r = (i / dim) % dim;
        c = i % dim;
        ew = (r % 2 == 1 && c % 2 == 1 && r < 2*(dim/2) && c < 2*(dim/2)) ? 4'hF : 4'h0;
        check("latency_we", 32'(we_of(sel)), 32'(ew));
      end
    end
  endtask

  task automatic drain(input int sel);
    set_nr(sel, 1'b1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Compare the collected outputs with the model, then clear both queues.
  task automatic cmp(input int sel, input string name);
    logic [31:0] got[$];
    if (sel == 0) got = qa;
    else          got = qb;
    check({name, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) check(name, got[i], exp_q[i]);
    if (sel == 0) qa.delete();
    else          qb.delete();
    exp_q.delete();
  endtask

  task automatic fill_pattern();
    frame_q.delete();
    for (int i = 0; i < 16; i++)
      frame_q.push_back({8'(i ^ 8), 8'(i * 3), 8'(15 - i), 8'(i)});
  endtask

  task automatic lane0_check();
    logic [31:0] t;
    int exp0[4];
    exp0 = '{5, 7, 13, 15};
    for (int k = 0; k < 4 && k < qa.size(); k++) begin
      t = qa[k];
      check("lane0_raster", 32'(t[7:0]), 32'(exp0[k]));
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst = 1'b1; b_rst = 1'b1; a_we = 4'h0; b_we = 4'h0; a_data = '0; b_data = '0;
    a_start = 1'b0; b_start = 1'b0; a_nr = 1'b1; b_nr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    a_rst = 1'b0; b_rst = 1'b0;
    #1;
    check("rst_a_ready", 32'(a_ready), 32'h1);
    check("rst_a_we", 32'(a_nwe), 32'h0);
    check("rst_a_start", 32'(a_nstart), 32'h0);
    check("rst_a_data", a_ndata, 32'h0);
    check("rst_b_ready", 32'(b_ready), 32'h1);
    check("rst_b_data", b_ndata, 32'h0);

    // Raster 0..15 on lane 0. The other lanes carry distinct derived patterns.
    fill_pattern();
    model(4, 1'b0, 0);
    send(0, 4, 0, 16, 1'b0, 1'b1);
    drain(0);
    lane0_check();
    cmp(0, "raster");

    // Single-window vectors. Each one sits in the top-left window of an otherwise zero 4x4 frame.
    tbl[0] = '{32'h04030201, 32'h01040302, 32'h02010403, 32'h03020104, 32'h04040404};
    tbl[1] = '{32'h55555555, 32'h55555555, 32'h55555555, 32'h55555555, 32'h55555555};
    tbl[2] = '{32'hFD007F80, 32'h80FF807F, 32'hFF010000, 32'hF9FE0101, 32'hFFFF8080};
    tbl[3] = '{32'h10203040, 32'h11213141, 32'h0F2A2F3F, 32'h12003242, 32'h122A3242};
    tbl[4] = '{32'hFE8001FD, 32'h02808080, 32'hFF807FFF, 32'h0080FFF9, 32'hFF80FFFF};
    for (int v = 0; v < 5; v++) begin
      frame_q.delete();
      for (int i = 0; i < 16; i++) frame_q.push_back(32'h0);
      frame_q[0] = tbl[v].w0; frame_q[1] = tbl[v].w1;
      frame_q[4] = tbl[v].w2; frame_q[5] = tbl[v].w3;
      exp_q.push_back(tbl[v].exp);
      for (int k = 0; k < 3; k++) exp_q.push_back(32'h0);
      send(0, 4, 0, 16, 1'b0, 1'b1);
      drain(0);
      cmp(0, "table");
    end

    // Signed instance: the same window bits, compared as two's complement.
    frame_q.delete();
    for (int i = 0; i < 25; i++) frame_q.push_back(32'h0);
    frame_q[0] = 32'hFE8001FD; frame_q[1] = 32'h02808080;
    frame_q[5] = 32'hFF807FFF; frame_q[6] = 32'h0080FFF9;
    exp_q.push_back(32'h02807FFF);
    for (int k = 0; k < 3; k++) exp_q.push_back(32'h0);
    send(1, 5, 0, 25, 1'b0, 1'b1);
    drain(1);
    cmp(1, "signed_win");

    // 5x5 instance: two identical frames back to back, four results each.
    frame_q.delete();
    for (int i = 0; i < 25; i++) frame_q.push_back($urandom);
    for (int i = 0; i < 25; i++) frame_q.push_back(frame_q[i]);
    model(5, 1'b1, 0);
    model(5, 1'b1, 25);
    send(1, 5, 0, 50, 1'b0, 1'b1);
    drain(1);
    cmp(1, "odd_dim");

    // Downstream stall when window (1,1) completes. Writes during the stall are dropped.
    fill_pattern();
    model(4, 1'b0, 0);
    send(0, 4, 0, 5, 1'b0, 1'b1);
    a_nr = 1'b0;
    drv(0, 4'hF, frame_q[5]);
    @(posedge clk); #1;
    drv(0, 4'h0, 32'h0);
    check("stall_we", 32'(a_nwe), 32'h0);
    check("stall_ready", 32'(a_ready), 32'h0);
    for (int k = 0; k < 3; k++) begin
      drv(0, 4'hF, $urandom);
      @(posedge clk); #1;
      check("stall_drop_we", 32'(a_nwe), 32'h0);
      check("stall_drop_ready", 32'(a_ready), 32'h0);
    end
    drv(0, 4'h0, 32'h0);
    a_nr = 1'b1;
    @(posedge clk); #1;
    check("release_we", 32'(a_nwe), 32'hF);
    check("release_data", a_ndata, exp_q[0]);
    check("release_ready", 32'(a_ready), 32'h1);
    send(0, 4, 6, 16, 1'b0, 1'b1);
    drain(0);
    cmp(0, "stall");

    // Reset after six pixels. The next full frame must pool as if from scratch.
    frame_q.delete();
    for (int i = 0; i < 16; i++) frame_q.push_back($urandom);
    send(0, 4, 0, 6, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    a_rst = 1'b1;
    @(posedge clk); #1;
    a_rst = 1'b0;
    #1;
    check("midrst_ready", 32'(a_ready), 32'h1);
    check("midrst_we", 32'(a_nwe), 32'h0);
    qa.delete();
    fill_pattern();
    model(4, 1'b0, 0);
    send(0, 4, 0, 16, 1'b0, 1'b1);
    drain(0);
    lane0_check();
    cmp(0, "after_rst");

    // Random frames with random idle gaps and downstream stalls on both instances.
    frame_q.delete();
    for (int i = 0; i < 48; i++) frame_q.push_back($urandom);
    for (int f = 0; f < 3; f++) model(4, 1'b0, f * 16);
    send(0, 4, 0, 48, 1'b1, 1'b0);
    drain(0);
    cmp(0, "rand_a");

    frame_q.delete();
    for (int i = 0; i < 50; i++) frame_q.push_back($urandom);
    model(5, 1'b1, 0);
    model(5, 1'b1, 25);
    send(1, 5, 0, 50, 1'b1, 1'b0);
    drain(1);
    cmp(1, "rand_b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
